// File: rtl/cache_pkg.sv
// Shared types and width helpers for the set-associative instruction cache.
package cache_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FILL = 2'd2
    } cache_state_t;

    function automatic int tag_width(input int addr_w, input int words_b, input int sets_b);
        return addr_w - words_b - sets_b;
    endfunction

    // A directly mapped build still needs a 1-bit pointer/way index.
    function automatic int ptr_width(input int ways_b);
        return (ways_b > 0) ? ways_b : 1;
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: per-set valid bits, tag store and line store.
module cache_way_array #(
    parameter int LINE_WIDTH = 64,
    parameter int TAG_WIDTH  = 10,
    parameter int SETS_BITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flush,
    input  logic                  i_we,
    input  logic [SETS_BITS-1:0]  i_rd_set,
    input  logic [SETS_BITS-1:0]  i_wr_set,
    input  logic [TAG_WIDTH-1:0]  i_wr_tag,
    input  logic [LINE_WIDTH-1:0] i_wr_line,
    output logic                  o_rd_valid,
    output logic [TAG_WIDTH-1:0]  o_rd_tag,
    output logic [LINE_WIDTH-1:0] o_rd_line
);

    localparam int SETS = 1 << SETS_BITS;

    logic [SETS-1:0]       r_valid;
    logic [TAG_WIDTH-1:0]  r_tag_mem [SETS];
    (* ram_style = "block" *) logic [LINE_WIDTH-1:0] r_data_mem [SETS];

    // Valid bits: cleared together by reset or flush, set one at a time by a fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_set] <= 1'b1;
        end else begin
            r_valid <= r_valid;
        end
    end

    // Tag and line storage, written only on fill.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag_mem[i_wr_set]  <= i_wr_tag;
            r_data_mem[i_wr_set] <= i_wr_line;
        end
    end

    assign o_rd_valid = r_valid[i_rd_set];
    assign o_rd_tag   = r_tag_mem[i_rd_set];
    assign o_rd_line  = r_data_mem[i_rd_set];

endmodule

// File: rtl/cache_set_assoc_rr.sv
// Read-only N-way set-associative instruction cache with per-set round-robin replacement.
module cache_set_assoc_rr
    import cache_pkg::*;
#(
    parameter int DWIDTH        = 16,
    parameter int WORDS_BITS    = 2,
    parameter int SETS_BITS     = 4,
    parameter int WAYS_BITS     = 1,
    parameter int ADDR_IN_WIDTH = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     addr_in_valid,
    input  logic [ADDR_IN_WIDTH-1:0]                 addr_in,
    output logic                                     addr_in_ready,
    output logic                                     data_out_valid,
    output logic [DWIDTH-1:0]                        data_out,
    output logic                                     addr_out_valid,
    output logic [ADDR_IN_WIDTH-WORDS_BITS-1:0]      addr_out,
    input  logic                                     addr_out_ready,
    input  logic                                     data_in_valid,
    input  logic [(DWIDTH<<WORDS_BITS)-1:0]          data_in,
    input  logic                                     flush,
    output logic [CNT_WIDTH-1:0]                     hit_count,
    output logic [CNT_WIDTH-1:0]                     miss_count
);

    localparam int LINE_WIDTH = DWIDTH << WORDS_BITS;
    localparam int TAG_WIDTH  = tag_width(ADDR_IN_WIDTH, WORDS_BITS, SETS_BITS);
    localparam int WAYS       = 1 << WAYS_BITS;
    localparam int SETS       = 1 << SETS_BITS;
    localparam int PTR_W      = ptr_width(WAYS_BITS);
    localparam logic [PTR_W-1:0] PTR_MASK = PTR_W'(WAYS - 1);

    cache_state_t          r_state;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [SETS_BITS-1:0]  r_set;
    logic [PTR_W-1:0]      r_victim;
    logic [PTR_W-1:0]      r_rr [SETS];
    logic                  r_flush_pend;
    logic                  r_replay;
    logic                  r_dvalid;
    logic [DWIDTH-1:0]     r_data;
    logic [CNT_WIDTH-1:0]  r_hit_cnt;
    logic [CNT_WIDTH-1:0]  r_miss_cnt;

    logic [WORDS_BITS-1:0] w_word;
    logic [SETS_BITS-1:0]  w_set;
    logic [TAG_WIDTH-1:0]  w_tag;
    logic [WAYS-1:0]       w_way_valid;
    logic [TAG_WIDTH-1:0]  w_way_tag  [WAYS];
    logic [LINE_WIDTH-1:0] w_way_line [WAYS];
    logic [WAYS-1:0]       w_hit_vec;
    logic [LINE_WIDTH-1:0] w_hit_line;
    logic [PTR_W-1:0]      w_victim;
    logic [WAYS-1:0]       w_we;
    logic                  w_idle;
    logic                  w_flush_now;
    logic                  w_accept;
    logic                  w_fetch;
    logic                  w_fill;

    assign w_word = addr_in[WORDS_BITS-1:0];
    assign w_set  = addr_in[WORDS_BITS +: SETS_BITS];
    assign w_tag  = addr_in[ADDR_IN_WIDTH-1 -: TAG_WIDTH];

    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
        assign w_we[gw] = w_fill && (r_victim == PTR_W'(gw));
        cache_way_array #(
            .LINE_WIDTH (LINE_WIDTH),
            .TAG_WIDTH  (TAG_WIDTH),
            .SETS_BITS  (SETS_BITS)
        ) u_way (
            .clk        (clk),
            .rst        (rst),
            .i_flush    (w_flush_now),
            .i_we       (w_we[gw]),
            .i_rd_set   (w_set),
            .i_wr_set   (r_set),
            .i_wr_tag   (r_tag),
            .i_wr_line  (data_in),
            .o_rd_valid (w_way_valid[gw]),
            .o_rd_tag   (w_way_tag[gw]),
            .o_rd_line  (w_way_line[gw])
        );
    end

    // Tag compare across ways; at most one way matches, so OR-ing masked lines selects it.
    always_comb begin
        w_hit_vec  = '0;
        w_hit_line = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = w_way_valid[w] && (w_way_tag[w] == w_tag);
            w_hit_line   = w_hit_line | (w_way_line[w] & {LINE_WIDTH{w_hit_vec[w]}});
        end
    end

    // Victim: lowest-index invalid way, else the set's round-robin pointer.
    always_comb begin
        w_victim = r_rr[w_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            w_victim = (!w_way_valid[w]) ? PTR_W'(w) : w_victim;
        end
    end

    assign w_idle      = (r_state == S_IDLE);
    assign w_flush_now = w_idle && (flush || r_flush_pend);
    assign w_accept    = w_idle && addr_in_valid && (|w_hit_vec) && !w_flush_now;
    assign w_fetch     = w_idle && addr_in_valid && !(|w_hit_vec) && !w_flush_now;
    assign w_fill      = (r_state == S_WAIT) && data_in_valid;

    // Miss-handling FSM, RR pointers and deferred flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_tag        <= '0;
            r_set        <= '0;
            r_victim     <= '0;
            r_flush_pend <= 1'b0;
            r_replay     <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            if (w_idle) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end else begin
                r_flush_pend <= r_flush_pend;
            end

            if (w_accept) begin
                r_replay <= 1'b0;
            end else if (w_fetch && addr_out_ready) begin
                r_replay <= 1'b1;
            end else begin
                r_replay <= r_replay;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fetch && addr_out_ready) begin
                        r_tag    <= w_tag;
                        r_set    <= w_set;
                        r_victim <= w_victim;
                        r_state  <= S_WAIT;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (data_in_valid) begin
                        r_rr[r_set] <= (r_rr[r_set] + PTR_W'(1)) & PTR_MASK;
                        r_state     <= S_FILL;
                    end else begin
                        r_state     <= S_WAIT;
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered response and counters; a replayed miss is not counted as a hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvalid   <= 1'b0;
            r_data     <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_dvalid <= w_accept;
            if (w_accept) begin
                r_data <= w_hit_line[w_word*DWIDTH +: DWIDTH];
            end else begin
                r_data <= r_data;
            end
            if (w_accept && !r_replay) begin
                r_hit_cnt <= r_hit_cnt + CNT_WIDTH'(1);
            end else begin
                r_hit_cnt <= r_hit_cnt;
            end
            if (w_fetch && addr_out_ready) begin
                r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            end else begin
                r_miss_cnt <= r_miss_cnt;
            end
        end
    end

    assign addr_in_ready  = w_accept;
    assign addr_out_valid = w_fetch;
    assign addr_out       = addr_in[ADDR_IN_WIDTH-1:WORDS_BITS];
    assign data_out_valid = r_dvalid;
    assign data_out       = r_data;
    assign hit_count      = r_hit_cnt;
    assign miss_count     = r_miss_cnt;

endmodule

// File: tb/tb_cache_set_assoc_rr.sv
// Scoreboard bench for cache_set_assoc_rr: directed reads against a memory model.
module tb_cache_set_assoc_rr;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_in_valid;
    logic [15:0] addr_in;
    logic        addr_in_ready;
    logic        data_out_valid;
    logic [15:0] data_out;
    logic        addr_out_valid;
    logic [13:0] addr_out;
    logic        addr_out_ready;
    logic        data_in_valid;
    logic [63:0] data_in;
    logic        flush;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int checks   = 0;
    int failures = 0;
    int exp_hits = 0;
    int exp_miss = 0;
    logic [15:0] exp_q [$];

    cache_set_assoc_rr dut (
        .clk            (clk),
        .rst            (rst),
        .addr_in_valid  (addr_in_valid),
        .addr_in        (addr_in),
        .addr_in_ready  (addr_in_ready),
        .data_out_valid (data_out_valid),
        .data_out       (data_out),
        .addr_out_valid (addr_out_valid),
        .addr_out       (addr_out),
        .addr_out_ready (addr_out_ready),
        .data_in_valid  (data_in_valid),
        .data_in        (data_in),
        .flush          (flush),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [13:0] la);
        logic [63:0] l;
        if (la == 14'h0004) begin
            l = 64'hDDDD_CCCC_BBBB_AAAA;
        end else begin
            for (int k = 0; k < 4; k++) l[k*16 +: 16] = 16'(int'(la) * 4 + k) ^ 16'hA5A5;
        end
        return l;
    endfunction

    function automatic logic [15:0] word_of(input logic [15:0] a);
        logic [63:0] l;
        l = line_of(a[15:2]);
        return l[a[1:0]*16 +: 16];
    endfunction

    // Monitor: every registered response must match the oldest expected word.
    initial begin
        forever begin
            @(negedge clk);
            if (data_out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_data_out_valid", 64'(data_out), 64'hFFFF_FFFF);
                end else begin
                    chk("data_out", 64'(data_out), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic check_counters(input string tag);
        chk({tag, "_hit_count"}, 64'(hit_count), 64'(exp_hits));
        chk({tag, "_miss_count"}, 64'(miss_count), 64'(exp_miss));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; addr_in_valid = 1'b0; flush = 1'b0; data_in_valid = 1'b0; data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_hits = 0; exp_miss = 0;
    endtask

    task automatic do_flush();
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0;
    endtask

    // Issues one read, serves any line fetches, expects exp_fetch fetches (-1: don't care).
    task automatic do_read(input logic [15:0] a, input int exp_fetch, input int lat,
                           input bit flush_mid, input bit flush_first);
        int fetches = 0;
        bit done = 1'b0;
        bit filled = 1'b0;
        bit pend_flush = flush_mid;
        @(negedge clk);
        addr_in = a; addr_in_valid = 1'b1;
        if (flush_first) begin
            flush = 1'b1;
            #1;
            chk("flush_blocks_ready", 64'(addr_in_ready), 64'd0);
            chk("flush_blocks_fetch", 64'(addr_out_valid), 64'd0);
            @(negedge clk); flush = 1'b0;
        end
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            #1;
            if (filled) begin
                chk("miss_latency", 64'(addr_in_ready), 64'd1);
                filled = 1'b0;
            end
            if (addr_in_ready) begin
                exp_q.push_back(word_of(a));
                if (fetches == 0) exp_hits++;
                if (exp_fetch == 0) chk("hit_same_cycle", 64'(cyc), 64'd0);
                @(posedge clk); #1;
                addr_in_valid = 1'b0;
                done = 1'b1;
            end else if (addr_out_valid) begin
                chk("addr_out", 64'(addr_out), 64'(a[15:2]));
                fetches++; exp_miss++;
                @(posedge clk);
                @(negedge clk); flush = pend_flush;
                @(negedge clk); flush = 1'b0;
                repeat (lat) @(negedge clk);
                data_in = line_of(a[15:2]); data_in_valid = 1'b1;
                @(negedge clk);
                data_in_valid = 1'b0; data_in = '0;
                #1;
                chk("fill_cycle_not_ready", 64'(addr_in_ready), 64'd0);
                filled = !pend_flush;
                pend_flush = 1'b0;
                @(negedge clk);
            end else begin
                @(negedge clk);
            end
        end
        chk("request_completed", 64'(done), 64'd1);
        if (exp_fetch >= 0) chk("fetch_count", 64'(fetches), 64'(exp_fetch));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; addr_in_valid = 1'b0; addr_in = '0; addr_out_ready = 1'b1;
        data_in_valid = 1'b0; data_in = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        chk("rst_data_out_valid", 64'(data_out_valid), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_addr_out_valid", 64'(addr_out_valid), 64'd0);
        chk("rst_addr_in_ready", 64'(addr_in_ready), 64'd0);

        // Cold miss then hit in the same line.
        do_read(16'h0012, 1, 3, 1'b0, 1'b0);
        check_counters("cold_miss");
        chk("cold_miss_count_is_1", 64'(miss_count), 64'd1);
        do_read(16'h0013, 0, 0, 1'b0, 1'b0);
        chk("first_hit_count_is_1", 64'(hit_count), 64'd1);

        // Two-way round robin in set 4, starting from fresh pointers.
        do_reset();
        do_read(16'h0010, 1, 1, 1'b0, 1'b0);
        do_read(16'h0110, 1, 2, 1'b0, 1'b0);
        do_read(16'h0210, 1, 0, 1'b0, 1'b0);
        do_read(16'h0111, 0, 0, 1'b0, 1'b0);
        do_read(16'h0212, 0, 0, 1'b0, 1'b0);
        do_read(16'h0010, 1, 1, 1'b0, 1'b0);
        do_read(16'h0213, 0, 0, 1'b0, 1'b0);
        do_read(16'h0110, 1, 1, 1'b0, 1'b0);
        check_counters("rr");

        // Hit, flush, re-read misses; then flush together with a request.
        do_read(16'h0112, 0, 0, 1'b0, 1'b0);
        do_flush();
        do_read(16'h0112, 1, 2, 1'b0, 1'b0);
        check_counters("after_flush");
        do_read(16'h0112, 1, 1, 1'b0, 1'b1);
        check_counters("flush_with_req");

        // Flush raised while waiting for memory: fill completes, then a second fetch.
        do_read(16'h0321, 2, 2, 1'b1, 1'b0);
        check_counters("flush_in_wait");

        // Reset while waiting: the late line must not be written.
        @(negedge clk);
        addr_in = 16'h0444; addr_in_valid = 1'b1;
        #1;
        chk("rst_wait_fetch", 64'(addr_out_valid), 64'd1);
        @(negedge clk);
        addr_in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; exp_hits = 0; exp_miss = 0;
        @(negedge clk);
        data_in = line_of(14'h0111); data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0; data_in = '0;
        #1;
        check_counters("rst_in_wait");
        chk("rst_in_wait_no_data", 64'(data_out_valid), 64'd0);
        do_read(16'h0444, 1, 1, 1'b0, 1'b0);
        do_read(16'h0112, 1, 1, 1'b0, 1'b0);
        check_counters("post_rst_wait");

        // Pseudo-random reads over a small footprint of conflicting lines.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            a = 16'((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 1)) << 2)
                    | 32'($urandom_range(0, 3)));
            do_read(a, -1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
        check_counters("random");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
